imem_loader: RTL and testbench

//  Byte-stream program loader: the write side of the instruction memory that the fetch stage reads by pc.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 55 +++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the imem program loader: FSM encoding, frame sync byte,
// and the width of the frame-length field.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_LOAD   = 3'd3,
        ST_CHK    = 3'd4
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_W     = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte shift assembler; word_done flags the 4th byte handshake and
// word_valid/word present the assembled word one cycle later.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_done,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic        wv_q, wv_d;
    logic [31:0] word_q, word_d;

    assign word_done  = in_valid && (idx_q == 2'd3);
    assign word_valid = wv_q;
    assign word       = word_q;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        wv_d    = 1'b0;
        word_d  = word_q;
        if (clr) begin
            idx_d = 2'd0;
        end else if (in_valid) begin
            shift_d = {shift_q[15:0], in_data};
            idx_d   = idx_q + 2'd1;
            // Only the last three bytes are kept; the 4th completes the word directly.
            if (idx_q == 2'd3) begin
                wv_d   = 1'b1;
                word_d = {shift_q, in_data};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
            wv_q    <= 1'b0;
            word_q  <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            wv_q    <= wv_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader feeding the imem write port and releasing the pipeline via start.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = 9,
    parameter int         DEPTH  = 512,
    parameter logic [7:0] SYNC   = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              abort,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              start,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, words_q, words_d, n_rx;
    logic [7:0]        cnt_hi_q, cnt_hi_d, chk_q, chk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_q, start_d, err_q, err_d, rdy_q;
    logic              hs, pk_valid, word_done;

    assign hs        = s_valid && rdy_q;
    assign s_ready   = rdy_q;
    assign imem_addr = addr_q;
    assign start     = start_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign n_rx      = {cnt_hi_q, s_data};
    // A byte arriving together with abort never reaches the assembler.
    assign pk_valid  = hs && !abort && (state_q == ST_LOAD);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state_q != ST_LOAD),
        .in_valid   (pk_valid),
        .in_data    (s_data),
        .word_done  (word_done),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_hi_d = cnt_hi_q;
        words_d  = words_q;
        chk_d    = chk_q;
        addr_d   = imem_we ? addr_q + 1'b1 : addr_q;
        start_d  = start_q;
        err_d    = err_q;
        if (abort) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                start_d = 1'b0;
                err_d   = 1'b1;
            end
        end else if (hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_data == SYNC) begin
                        state_d = ST_CNT_HI;
                        start_d = 1'b0;
                        err_d   = 1'b0;
                        words_d = '0;
                        chk_d   = '0;
                        addr_d  = '0;
                    end
                end
                ST_CNT_HI: begin
                    cnt_hi_d = s_data;
                    state_d  = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    if (n_rx == '0 || int'(n_rx) > DEPTH) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = n_rx;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    chk_d = chk_q ^ s_data;
                    if (word_done) begin
                        words_d = words_q + 1'b1;
                        if (words_d == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            // start becomes visible alongside the final imem write.
                            state_d = ST_IDLE;
                            start_d = 1'b1;
`endif
                        end
                    end
                end
                ST_CHK: begin
                    if (s_data == chk_q) start_d = 1'b1;
                    else                 err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cnt_hi_q <= '0;
            words_q  <= '0;
            chk_q    <= '0;
            addr_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cnt_hi_q <= cnt_hi_d;
            words_q  <= words_d;
            chk_q    <= chk_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            err_q    <= err_d;
            rdy_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              abort = 1'b0;
    logic              s_ready, imem_we, start, busy, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .abort(abort), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .start(start), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [40:0] wq[$];
    bit          sq[$];
    logic [40:0] exp_w[$];
    logic [7:0]  fb[$];
    logic [7:0]  pl[$];

    // Observed imem writes and the start level seen on each write cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wq.push_back({imem_addr, imem_wdata});
            sq.push_back(start);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        if (gaps && $urandom_range(3) == 0) begin
            s_valid = 1'b0;
            tick(1);
        end
        s_valid = 1'b1;
        s_data  = b;
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic send_fb(input bit gaps);
        foreach (fb[i]) send(fb[i], gaps);
    endtask

    // Reference model: frame bytes and expected writes derived from the payload in pl.
    task automatic build(input bit chk_ok);
        logic [7:0] x;
        int n;
        x = 8'h00;
        n = pl.size() / 4;
        fb.delete();
        exp_w.delete();
        fb.push_back(8'hA5);
        fb.push_back(8'(n >> 8));
        fb.push_back(8'(n));
        foreach (pl[i]) begin
            fb.push_back(pl[i]);
            x = x ^ pl[i];
        end
        for (int w = 0; w < n; w++)
            exp_w.push_back({9'(w), pl[4*w], pl[4*w+1], pl[4*w+2], pl[4*w+3]});
        if (CHK) fb.push_back(chk_ok ? x : ~x);
    endtask

    task automatic clear_obs();
        wq.delete();
        sq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_checks++;
        if ({s_ready, imem_we, imem_addr, imem_wdata, start, busy, err} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {s_ready, imem_we, imem_addr, imem_wdata, start, busy, err});
        else n_pass++;
        rst_n = 1'b1;
        tick(1);
        n_checks++;
        if ({s_ready, busy} !== 2'b10) $display("FAIL reset_release: got %b want 10", {s_ready, busy});
        else n_pass++;
    endtask

    task automatic test_basic();
        pl = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        build(1'b1);
        clear_obs();
        send_fb(1'b0);
        tick(3);
        n_checks++;
        if (wq.size() !== 2) $display("FAIL basic_count: got %0d want 2", wq.size());
        else n_pass++;
        foreach (exp_w[i]) if (i < wq.size()) begin
            n_checks++;
            if (wq[i] !== exp_w[i]) $display("FAIL basic_word%0d: got %h want %h", i, wq[i], exp_w[i]);
            else n_pass++;
        end
        if (sq.size() == 2) begin
            n_checks++;
            if ({sq[0], sq[1]} !== {1'b0, !CHK})
                $display("FAIL basic_start_at_write: got %b want %b", {sq[0], sq[1]}, {1'b0, !CHK});
            else n_pass++;
        end
        n_checks++;
        if ({start, err, busy} !== 3'b100) $display("FAIL basic_final: got %b want 100", {start, err, busy});
        else n_pass++;
    endtask

    task automatic test_bad_count();
        clear_obs();
        send(8'h00, 1'b0);
        send(8'h11, 1'b0);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL junk_busy: got %b want 0", busy);
        else n_pass++;
        send(8'hA5, 1'b0);
        n_checks++;
        if ({busy, start} !== 2'b10) $display("FAIL sync_busy_start: got %b want 10", {busy, start});
        else n_pass++;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        tick(1);
        n_checks++;
        if ({err, start, busy} !== 3'b100 || wq.size() != 0)
            $display("FAIL zero_count: got err/start/busy=%b writes=%0d want 100 writes=0",
                     {err, start, busy}, wq.size());
        else n_pass++;
    endtask

    task automatic test_too_big();
        clear_obs();
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h01, 1'b0);
        tick(4);
        n_checks++;
        if ({err, start, busy} !== 3'b100 || wq.size() != 0)
            $display("FAIL over_depth: got err/start/busy=%b writes=%0d want 100 writes=0",
                     {err, start, busy}, wq.size());
        else n_pass++;
    endtask

    task automatic test_max_depth();
        int bad;
        pl.delete();
        for (int i = 0; i < 4 * DEPTH; i++) pl.push_back(8'($urandom_range(255)));
        build(1'b1);
        clear_obs();
        send_fb(1'b0);
        tick(3);
        bad = 0;
        foreach (exp_w[i]) if (i >= wq.size() || wq[i] !== exp_w[i]) bad++;
        n_checks++;
        if (wq.size() !== DEPTH || bad != 0)
            $display("FAIL max_depth: got %0d writes %0d wrong want %0d writes 0 wrong", wq.size(), bad, DEPTH);
        else n_pass++;
        n_checks++;
        if ({start, err} !== 2'b10) $display("FAIL max_depth_flags: got %b want 10", {start, err});
        else n_pass++;
    endtask

    task automatic test_abort();
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom_range(255)));
        build(1'b1);
        clear_obs();
        for (int i = 0; i < 13; i++) send(fb[i], 1'b1);
        // A SYNC byte presented with abort must be discarded.
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick(1);
        abort   = 1'b0;
        s_valid = 1'b0;
        for (int i = 13; i < fb.size(); i++) send(fb[i], 1'b0);
        tick(3);
        n_checks++;
        if (wq.size() !== 2) $display("FAIL abort_count: got %0d want 2", wq.size());
        else n_pass++;
        for (int i = 0; i < 2; i++) if (i < wq.size()) begin
            n_checks++;
            if (wq[i] !== exp_w[i]) $display("FAIL abort_word%0d: got %h want %h", i, wq[i], exp_w[i]);
            else n_pass++;
        end
        n_checks++;
        if ({err, start, busy} !== 3'b100) $display("FAIL abort_flags: got %b want 100", {err, start, busy});
        else n_pass++;
        send(8'hA5, 1'b0);
        n_checks++;
        if ({err, busy} !== 2'b01) $display("FAIL abort_resync: got %b want 01", {err, busy});
        else n_pass++;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(1'b1);
        for (int i = 1; i < fb.size(); i++) send(fb[i], 1'b0);
        tick(2);
        n_checks++;
        if ({start, err} !== 2'b10) $display("FAIL abort_reload: got %b want 10", {start, err});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom_range(255)));
        build(1'b1);
        clear_obs();
        for (int i = 0; i < 9; i++) send(fb[i], 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, imem_we, imem_addr, imem_wdata, start, busy, err} !== '0)
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {s_ready, imem_we, imem_addr, imem_wdata, start, busy, err});
        else n_pass++;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_obs();
        send_fb(1'b1);
        tick(3);
        n_checks++;
        if (wq.size() !== 3 || wq[0] !== exp_w[0] || wq[2] !== exp_w[2])
            $display("FAIL reset_mid_reload: got %0d writes want 3 matching model", wq.size());
        else n_pass++;
        n_checks++;
        if ({start, err} !== 2'b10) $display("FAIL reset_mid_flags: got %b want 10", {start, err});
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int n, junk;
            bit ok;
            logic [7:0] b;
            n    = $urandom_range(1, 6);
            junk = $urandom_range(0, 3);
            ok   = 1'($urandom_range(1));
            pl.delete();
            for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom_range(255)));
            build(ok);
            clear_obs();
            for (int j = 0; j < junk; j++) begin
                b = 8'($urandom_range(255));
                if (b == 8'hA5) b = 8'h3C;
                send(b, 1'b1);
            end
            send_fb(1'b1);
            tick(3);
            n_checks++;
            if (wq.size() !== exp_w.size()) $display("FAIL rand%0d_count: got %0d want %0d", f, wq.size(), exp_w.size());
            else n_pass++;
            foreach (exp_w[i]) if (i < wq.size()) begin
                n_checks++;
                if (wq[i] !== exp_w[i]) $display("FAIL rand%0d_word%0d: got %h want %h", f, i, wq[i], exp_w[i]);
                else n_pass++;
            end
            n_checks++;
            if ({start, err, busy} !== {(!CHK || ok), (CHK && !ok), 1'b0})
                $display("FAIL rand%0d_flags: got %b want %b", f, {start, err, busy},
                         {(!CHK || ok), (CHK && !ok), 1'b0});
            else n_pass++;
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] cks[2];
        cks[0] = 8'h08;
        cks[1] = 8'h09;
        for (int k = 0; k < 2; k++) begin
            fb = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
            fb.push_back(cks[k]);
            clear_obs();
            send_fb(1'b0);
            tick(2);
            n_checks++;
            if (wq.size() !== 1 || wq[0] !== {9'd0, 32'h12345678})
                $display("FAIL chk%0d_write: got %0d writes want 1 of 12345678", k, wq.size());
            else n_pass++;
            n_checks++;
            if ({start, err} !== ((k == 0) ? 2'b10 : 2'b01))
                $display("FAIL chk%0d_flags: got %b want %b", k, {start, err}, (k == 0) ? 2'b10 : 2'b01);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_count();
        test_too_big();
        test_abort();
        test_reset_mid();
        test_random();
        test_max_depth();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
